pwm_step_scheduler: RTL
=======================

PWM_STEP_SCHEDULER -- requirements
Module: pwm_step_scheduler

Interface
REQ-001 SHALL have parameter LEVELS, default 10: number of duty steps above zero, legal range 1..15.
REQ-002 SHALL have parameter STEP_GAP, default 1000: cycles between automatic steps, legal range 2..65535.
REQ-003 SHALL have parameter HOLD_CYCLES, default 5000: dwell cycles at top and bottom in auto mode, legal range 1..65535.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port key_up_pulse, input, 1 bit: debounced one-cycle manual increment request.
REQ-007 SHALL have port key_down_pulse, input, 1 bit: debounced one-cycle manual decrement request.
REQ-008 SHALL have port key_mode_pulse, input, 1 bit: debounced one-cycle manual/auto toggle request.
REQ-009 SHALL have port step_up, output, 1 bit: one-cycle increment command to the PWM controller.
REQ-010 SHALL have port step_down, output, 1 bit: one-cycle decrement command to the PWM controller.
REQ-011 SHALL have port level, output, 4 bits: shadow of the current duty step, range 0..LEVELS.
REQ-012 SHALL have port auto_mode, output, 1 bit: 1 whenever the state is not MANUAL.

Function
REQ-013 SHALL implement FSM states MANUAL, RAMP_UP, HOLD_HI, RAMP_DOWN and HOLD_LO.
REQ-014 SHALL register every output, so step_up, step_down, level and auto_mode change only on clock edges.
REQ-015 SHALL, in MANUAL, on key_up_pulse sampled at cycle t with level<LEVELS, assert step_up for exactly cycle t+1, with level incremented in that same cycle.
REQ-016 SHALL, in MANUAL, on key_down_pulse sampled at cycle t with level>0, assert step_down for exactly cycle t+1, with level decremented in that same cycle.
REQ-017 SHALL ignore key_up_pulse at level==LEVELS, ignore key_down_pulse at level==0, and ignore both when they are sampled in the same cycle; an ignored request produces no pulse and no level change.
REQ-018 SHALL never assert step_up and step_down in the same cycle.
REQ-019 SHALL, on key_mode_pulse in MANUAL, enter RAMP_DOWN when level==LEVELS and RAMP_UP otherwise, with the new state taking effect next cycle.
REQ-020 SHALL, on key_mode_pulse in any auto state, enter MANUAL next cycle, cancel any pending step, emit no pulse in that cycle, and retain level.
REQ-021 SHALL give key_mode_pulse priority over key_up_pulse and key_down_pulse sampled in the same cycle, and drop those key pulses.
REQ-022 SHALL ignore key_up_pulse and key_down_pulse in all auto states.
REQ-023 SHALL, in RAMP_UP and RAMP_DOWN with entry cycle E, issue steps at cycles E+STEP_GAP-1, then every STEP_GAP cycles after that.
REQ-024 SHALL enter HOLD_HI in the cycle after the step_up that makes level==LEVELS.
REQ-025 SHALL enter HOLD_LO in the cycle after the step_down that makes level==0.
REQ-026 SHALL occupy HOLD_HI or HOLD_LO for exactly HOLD_CYCLES cycles, then enter RAMP_DOWN or RAMP_UP respectively.
REQ-027 SHALL use a 16-bit gap/hold counter that is cleared on every state entry and never wraps.
REQ-028 SHALL keep level within 0..LEVELS under all input sequences.

Reset
REQ-029 SHALL, while rst==0, immediately force state=MANUAL, level=0, step_up=0, step_down=0, auto_mode=0 and counter=0, regardless of clk.
REQ-030 SHALL, on reset assertion mid-ramp or mid-hold, discard the pending step, so that no pulse appears in the first cycle after release.
REQ-031 SHALL accept inputs from the first rising clk edge after rst deasserts.

Verification (LEVELS=3, STEP_GAP=4, HOLD_CYCLES=6 unless stated)
REQ-032 SHALL cover: after reset, key_up_pulse at cycles 0, 5, 10, 15 -> step_up at cycles 1, 6, 11 only; level reads 1, 2, 3 and stays 3.
REQ-033 SHALL cover: level=2, key_up_pulse and key_down_pulse both at one cycle -> no pulse; level stays 2. Then key_down_pulse at cycle 0 with level=0 -> no pulse.
REQ-034 SHALL cover: level=0, key_mode_pulse at cycle 0 -> auto_mode=1 from cycle 1; step_up at 4, 8, 12; HOLD_HI for cycles 13-18; step_down at 22, 26, 30; HOLD_LO for cycles 31-36; step_up at 40.
REQ-035 SHALL cover: in auto mode, key_mode_pulse together with key_up_pulse at cycle 6 -> MANUAL at cycle 7; no pulse at cycle 7 or 8; level held at 1.
REQ-036 SHALL cover: level=3, key_mode_pulse -> RAMP_DOWN; first step_down 4 cycles after the pulse.
REQ-037 SHALL cover: rst asserted mid-ramp, between edges -> outputs zero at once; after release, idle with no step pulses until a key input arrives.

Source files
------------

// File: rtl/pwm_step_scheduler.sv
// Turns debounced key pulses into one-cycle step commands for a PWM duty controller,
// either manually or via an automatic ramp-up / hold / ramp-down / hold cycle.
module pwm_step_scheduler #(
    parameter int LEVELS      = 10,
    parameter int STEP_GAP    = 1000,
    parameter int HOLD_CYCLES = 5000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_up_pulse,
    input  logic       key_down_pulse,
    input  logic       key_mode_pulse,
    output logic       step_up,
    output logic       step_down,
    output logic [3:0] level,
    output logic       auto_mode,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        MANUAL    = 3'd0,
        RAMP_UP   = 3'd1,
        HOLD_HI   = 3'd2,
        RAMP_DOWN = 3'd3,
        HOLD_LO   = 3'd4
    } state_t;

    localparam logic [3:0]  LVL_MAX   = 4'(LEVELS);
    localparam logic [15:0] GAP_LAST  = 16'(STEP_GAP - 1);
    localparam logic [15:0] GAP_FIRE  = 16'(STEP_GAP - 2);
    localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);

    state_t      state, state_nxt;
    logic [15:0] cnt, cnt_nxt;
    logic [3:0]  level_nxt;
    logic        up_nxt, down_nxt;

    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= MANUAL;
            cnt       <= '0;
            level     <= '0;
            step_up   <= 1'b0;
            step_down <= 1'b0;
            auto_mode <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            level     <= level_nxt;
            step_up   <= up_nxt;
            step_down <= down_nxt;
            auto_mode <= (state_nxt != MANUAL);
        end
    end

    // Step commands are decided one cycle early so they leave the block registered,
    // together with the matching level update.
    always_comb begin
        state_nxt = state;
        up_nxt    = 1'b0;
        down_nxt  = 1'b0;
        case (state)
            MANUAL: begin
                if (key_mode_pulse)
                    state_nxt = (level == LVL_MAX) ? RAMP_DOWN : RAMP_UP;
                else if (key_up_pulse && !key_down_pulse && level < LVL_MAX)
                    up_nxt = 1'b1;
                else if (key_down_pulse && !key_up_pulse && level != 4'd0)
                    down_nxt = 1'b1;
            end
            RAMP_UP: begin
                if (key_mode_pulse)
                    state_nxt = MANUAL;
                else if (level >= LVL_MAX)
                    state_nxt = HOLD_HI;
                else if (cnt == GAP_FIRE)
                    up_nxt = 1'b1;
            end
            RAMP_DOWN: begin
                if (key_mode_pulse)
                    state_nxt = MANUAL;
                else if (level == 4'd0)
                    state_nxt = HOLD_LO;
                else if (cnt == GAP_FIRE)
                    down_nxt = 1'b1;
            end
            HOLD_HI: begin
                if (key_mode_pulse)
                    state_nxt = MANUAL;
                else if (cnt == HOLD_LAST)
                    state_nxt = RAMP_DOWN;
            end
            HOLD_LO: begin
                if (key_mode_pulse)
                    state_nxt = MANUAL;
                else if (cnt == HOLD_LAST)
                    state_nxt = RAMP_UP;
            end
            default: state_nxt = MANUAL;
        endcase
    end

    always_comb begin
        level_nxt = level;
        if (up_nxt)
            level_nxt = level + 4'd1;
        else if (down_nxt)
            level_nxt = level - 4'd1;
    end

    // Ramp counter runs modulo STEP_GAP from the entry cycle; hold counter saturates.
    always_comb begin
        cnt_nxt = '0;
        if (state_nxt == state) begin
            case (state)
                RAMP_UP, RAMP_DOWN: cnt_nxt = (cnt >= GAP_LAST) ? 16'd0 : cnt + 16'd1;
                HOLD_HI, HOLD_LO:   cnt_nxt = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
                default:            cnt_nxt = '0;
            endcase
        end
    end

endmodule
